flash_read_arbiter: RTL and testbench
=====================================

// Module: flash_read_arbiter
// PURPOSE
// Shares the single Avalon-MM read port of the flash core between two read requesters.
// Example requesters: audio sample fetch and a secondary loader/checker.
// Grants are round-robin, with one outstanding flash read at a time.
// Read data is routed back to the requester that issued the read.
// A response timeout keeps a stalled flash from hanging either client.
// Sits between the requester FSMs and the flash instance in the top level.
// PARAMETERS
// ADDR_W   23   flash word-address width
// DATA_W   32   flash read-data width
// TIMEOUT  1024 max cycles in WAIT_DATA before forced completion; 0 disables timeout
// PORTS
// clk                      in   1              system clock (CLOCK_50 domain)
// rst_n                    in   1              asynchronous active-low reset
// rq_read                  in   2              per-requester read request; bit i = requester i
// rq_addr                  in   2*ADDR_W       request addresses; [ADDR_W-1:0] = requester 0
// rq_waitrequest           out  2              per-requester stall; low = command accepted this edge
// rq_readdata              out  DATA_W         returned data, shared bus, valid with rq_readdatavalid
// rq_readdatavalid         out  2              one-cycle pulse to the owning requester
// flash_mem_read           out  1              flash read strobe
// flash_mem_address        out  ADDR_W         flash address
// flash_mem_byteenable     out  4              constant 4'b1111
// flash_mem_waitrequest    in   1              flash stall
// flash_mem_readdata       in   DATA_W         flash data
// flash_mem_readdatavalid  in   1              flash data strobe
// busy                     out  1              high whenever state != IDLE
// timeout_err              out  1              sticky; set on any timeout, cleared only by reset
// BEHAVIOUR
// Reset values (async, rst_n=0):
//  - state=IDLE, flash_mem_read=0, flash_mem_address=0, rq_readdata=0
//  - rq_readdatavalid=0, timeout_err=0, owner=0, last_grant=1 (so requester 0 wins first)
//  - timeout counter=0
// rq_waitrequest[i] is combinational: 0 only when state==IDLE and requester i is selected, else 1.
// Requesters hold rq_read and their address until they see rq_waitrequest low at a posedge.
// Selection in IDLE:
//  - one requester active -> that requester
//  - both active -> the requester != last_grant
// Capture edge: owner<=sel, last_grant<=sel, flash_mem_address<=rq_addr[sel], flash_mem_read<=1.
//  - Go to ISSUE.
// ISSUE:
//  - flash_mem_read stays 1 and address stays stable while flash_mem_waitrequest=1.
//  - On the edge where waitrequest=0: flash_mem_read<=0, counter<=0, go to WAIT_DATA.
// WAIT_DATA, on flash_mem_readdatavalid=1:
//  - rq_readdata<=flash_mem_readdata, rq_readdatavalid[owner]<=1 for exactly one cycle
//  - go to IDLE
// WAIT_DATA, else when TIMEOUT!=0 and counter==TIMEOUT-1:
//  - rq_readdata<=0, rq_readdatavalid[owner]<=1 for one cycle, timeout_err<=1
//  - go to IDLE
// WAIT_DATA, otherwise: counter increments.
// Latency, zero flash stall, flash data N cycles after acceptance:
//  - rq_readdatavalid is high N+1 cycles after the acceptance edge.
//  - Next grant is possible in the IDLE cycle that coincides with the valid pulse.
// flash_mem_readdatavalid seen in IDLE or ISSUE is stray and ignored; no pulse, no state change.
// Simultaneous new request and completion: no grant on the completion edge; grant next IDLE cycle.
// Address is passed through unmodified; no wrap or increment here.
// Reset mid-read forces IDLE; a late flash response after reset is ignored as stray.
// rq_readdatavalid is never high on both bits at once.
// TESTING
// 1. Req0 only, addr 0x000010, flash accepts at once, data 0xDEADBEEF 3 cycles later
//    -> rq_readdatavalid=2'b01 one cycle, rq_readdata=0xDEADBEEF, flash addr 0x000010.
// 2. Both requesting continuously, addr0=0x100, addr1=0x200
//    -> flash addresses alternate 0x100,0x200,0x100,...; valid pulses alternate 01,10,01.
// 3. flash_mem_waitrequest held high 5 cycles in ISSUE
//    -> flash_mem_read held 1 with stable address all 5 cycles; drops the edge after waitrequest falls.
// 4. TIMEOUT=8, flash never returns data
//    -> after 8 WAIT_DATA cycles owner gets valid with data 0; timeout_err=1 stays set; next request served.
// 5. rst_n pulsed low in WAIT_DATA, flash valid arrives after release
//    -> all outputs at reset values; no rq_readdatavalid; busy=0.
// 6. Stray flash_mem_readdatavalid in IDLE -> no valid pulse, state remains IDLE.

Source files
------------

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : flash_read_arbiter
//  Purpose  : Shares the single Avalon-MM read port of the flash core between
//             two read requesters. Round-robin grants, one outstanding read,
//             read data routed back to the issuing requester, and a response
//             timeout so a stalled flash cannot hang either client.
//  Ports    : clk, rst_n                     clock / async active-low reset
//             rq_read, rq_addr               per-requester command inputs
//             rq_waitrequest                 per-requester stall (comb.)
//             rq_readdata, rq_readdatavalid  shared data bus, per-owner strobe
//             flash_mem_*                    Avalon-MM master to flash core
//             busy, timeout_err              status (timeout_err is sticky)
//  Revision : 1.0  initial release
// ============================================================================
module flash_read_arbiter #(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            rq_read,
   input  logic [2*ADDR_W-1:0]   rq_addr,
   output logic [1:0]            rq_waitrequest,
   output logic [DATA_W-1:0]     rq_readdata,
   output logic [1:0]            rq_readdatavalid,
   output logic                  flash_mem_read,
   output logic [ADDR_W-1:0]     flash_mem_address,
   output logic [3:0]            flash_mem_byteenable,
   input  logic                  flash_mem_waitrequest,
   input  logic [DATA_W-1:0]     flash_mem_readdata,
   input  logic                  flash_mem_readdatavalid,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic                read_q, read_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rdv_q, rdv_d;
   logic                terr_q, terr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                sel;
   logic                idle;
   logic                timeout_hit;

   // Contention goes to whoever did not win last; otherwise the lone requester.
   assign sel         = (rq_read == 2'b11) ? ~last_grant_q : rq_read[1];
   assign idle        = (state_q == IDLE);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == c_cnt_last);

   assign rq_waitrequest[0]    = ~(idle && rq_read[0] && ~sel);
   assign rq_waitrequest[1]    = ~(idle && rq_read[1] &&  sel);
   assign rq_readdata          = rdata_q;
   assign rq_readdatavalid     = rdv_q;
   assign flash_mem_read       = read_q;
   assign flash_mem_address    = addr_q;
   assign flash_mem_byteenable = 4'b1111;
   assign busy                 = ~idle;
   assign timeout_err          = terr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         read_q       <= 1'b0;
         addr_q       <= '0;
         rdata_q      <= '0;
         rdv_q        <= 2'b00;
         terr_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         read_q       <= read_d;
         addr_q       <= addr_d;
         rdata_q      <= rdata_d;
         rdv_q        <= rdv_d;
         terr_q       <= terr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      read_d       = read_q;
      addr_d       = addr_q;
      rdata_d      = rdata_q;
      rdv_d        = 2'b00;          // valid is a single-cycle pulse
      terr_d       = terr_q;
      cnt_d        = cnt_q;

      case (state_q)
         IDLE: begin
            // A readdatavalid seen here is stray and deliberately ignored.
            if (|rq_read) begin
               owner_d      = sel;
               last_grant_d = sel;
               addr_d       = sel ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
               read_d       = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (!flash_mem_waitrequest) begin
               read_d  = 1'b0;
               cnt_d   = '0;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (flash_mem_readdatavalid) begin
               rdata_d        = flash_mem_readdata;
               rdv_d[owner_q] = 1'b1;
               state_d        = IDLE;
            end else if (timeout_hit) begin
               // Forced completion: owner gets zero data so it can move on.
               rdata_d        = '0;
               rdv_d[owner_q] = 1'b1;
               terr_d         = 1'b1;
               state_d        = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_read_arbiter
//  Purpose  : Directed self-checking bench for flash_read_arbiter (TIMEOUT=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_flash_read_arbiter;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 32;

   logic                clk;
   logic                rst_n;
   logic [1:0]          rq_read;
   logic [2*ADDR_W-1:0] rq_addr;
   logic [1:0]          rq_waitrequest;
   logic [DATA_W-1:0]   rq_readdata;
   logic [1:0]          rq_readdatavalid;
   logic                fm_read;
   logic [ADDR_W-1:0]   fm_addr;
   logic [3:0]          fm_be;
   logic                fm_wait;
   logic [DATA_W-1:0]   fm_rdata;
   logic                fm_rdv;
   logic                busy;
   logic                timeout_err;

   int total = 0;
   int bad   = 0;

   flash_read_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (8)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .rq_read                 (rq_read),
      .rq_addr                 (rq_addr),
      .rq_waitrequest          (rq_waitrequest),
      .rq_readdata             (rq_readdata),
      .rq_readdatavalid        (rq_readdatavalid),
      .flash_mem_read          (fm_read),
      .flash_mem_address       (fm_addr),
      .flash_mem_byteenable    (fm_be),
      .flash_mem_waitrequest   (fm_wait),
      .flash_mem_readdata      (fm_rdata),
      .flash_mem_readdatavalid (fm_rdv),
      .busy                    (busy),
      .timeout_err             (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [22:0] exp_addr;
      int          who;

      rst_n    = 1'b0;
      rq_read  = 2'b00;
      rq_addr  = '0;
      fm_wait  = 1'b0;
      fm_rdata = '0;
      fm_rdv   = 1'b0;
      tick();
      tick();

      // ---- reset state ----
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_read",  32'(fm_read), 32'd0);
      chk("rst_addr",  32'(fm_addr), 32'd0);
      chk("rst_rdata", rq_readdata, 32'd0);
      chk("rst_rdv",   32'(rq_readdatavalid), 32'd0);
      chk("rst_terr",  32'(timeout_err), 32'd0);
      chk("rst_wreq",  32'(rq_waitrequest), 32'd3);
      chk("byteen",    32'(fm_be), 32'hF);
      rst_n = 1'b1;

      // ---- 1: requester 0 alone, data 3 cycles after flash accepts ----
      rq_read = 2'b01;
      rq_addr = {23'h0, 23'h000010};
      #1;
      chk("t1_wreq_idle", 32'(rq_waitrequest), 32'd2);
      tick();                                     // arbiter acceptance edge
      chk("t1_read", 32'(fm_read), 32'd1);
      chk("t1_addr", 32'(fm_addr), 32'h10);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_wreq_issue", 32'(rq_waitrequest), 32'd3);
      rq_read = 2'b00;
      tick();                                     // flash accepts
      chk("t1_read_drop", 32'(fm_read), 32'd0);
      tick();
      tick();
      chk("t1_no_early_rdv", 32'(rq_readdatavalid), 32'd0);
      fm_rdv   = 1'b1;
      fm_rdata = 32'hDEADBEEF;
      tick();
      fm_rdv = 1'b0;
      chk("t1_rdv",   32'(rq_readdatavalid), 32'd1);
      chk("t1_rdata", rq_readdata, 32'hDEADBEEF);
      chk("t1_idle",  32'(busy), 32'd0);
      tick();
      chk("t1_rdv_one_cycle", 32'(rq_readdatavalid), 32'd0);

      // ---- 2: both requesting continuously after a fresh reset ----
      rst_n = 1'b0;
      #2;
      rst_n   = 1'b1;
      rq_read = 2'b11;
      rq_addr = {23'h000200, 23'h000100};
      for (int k = 0; k < 4; k++) begin
         who      = k % 2;
         exp_addr = (who == 0) ? 23'h000100 : 23'h000200;
         #1;
         chk("t2_wreq_grant", 32'(rq_waitrequest), (who == 0) ? 32'd2 : 32'd1);
         tick();
         chk("t2_addr", 32'(fm_addr), 32'(exp_addr));
         chk("t2_read", 32'(fm_read), 32'd1);
         tick();
         fm_rdv   = 1'b1;
         fm_rdata = 32'hA0000000 + 32'(k);
         tick();
         fm_rdv = 1'b0;
         chk("t2_rdv",   32'(rq_readdatavalid), (who == 0) ? 32'd1 : 32'd2);
         chk("t2_rdata", rq_readdata, 32'hA0000000 + 32'(k));
      end
      rq_read = 2'b00;
      tick();

      // ---- 3: flash stalls 5 cycles in ISSUE (stray valid during stall) ----
      rq_read = 2'b10;
      rq_addr = {23'h3ABCDE, 23'h000000};
      fm_wait = 1'b1;
      tick();
      rq_read = 2'b00;
      for (int i = 0; i < 5; i++) begin
         fm_rdv = (i == 2);
         tick();
         chk("t3_read_held", 32'(fm_read), 32'd1);
         chk("t3_addr_held", 32'(fm_addr), 32'h3ABCDE);
         chk("t3_no_rdv",    32'(rq_readdatavalid), 32'd0);
      end
      fm_rdv  = 1'b0;
      fm_wait = 1'b0;
      tick();
      chk("t3_read_drop", 32'(fm_read), 32'd0);
      fm_rdv   = 1'b1;
      fm_rdata = 32'h12345678;
      tick();
      fm_rdv = 1'b0;
      chk("t3_rdv",   32'(rq_readdatavalid), 32'd2);
      chk("t3_rdata", rq_readdata, 32'h12345678);

      // ---- 6: stray flash valid in IDLE ----
      tick();
      fm_rdv   = 1'b1;
      fm_rdata = 32'hBADBAD00;
      tick();
      fm_rdv = 1'b0;
      chk("t6_no_rdv", 32'(rq_readdatavalid), 32'd0);
      chk("t6_idle",   32'(busy), 32'd0);
      chk("t6_rdata_kept", rq_readdata, 32'h12345678);

      // ---- 4: flash never returns data, timeout after 8 WAIT_DATA cycles ----
      rq_read = 2'b01;
      rq_addr = {23'h0, 23'h000055};
      tick();
      rq_read = 2'b00;
      tick();                                     // now in WAIT_DATA
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t4_waiting_rdv",  32'(rq_readdatavalid), 32'd0);
         chk("t4_waiting_busy", 32'(busy), 32'd1);
      end
      chk("t4_terr_before", 32'(timeout_err), 32'd0);
      tick();
      chk("t4_rdv",   32'(rq_readdatavalid), 32'd1);
      chk("t4_rdata", rq_readdata, 32'd0);
      chk("t4_terr",  32'(timeout_err), 32'd1);
      chk("t4_idle",  32'(busy), 32'd0);
      rq_read = 2'b10;
      rq_addr = {23'h000066, 23'h0};
      tick();
      chk("t4_next_addr", 32'(fm_addr), 32'h66);
      rq_read = 2'b00;
      tick();
      fm_rdv   = 1'b1;
      fm_rdata = 32'hCAFEF00D;
      tick();
      fm_rdv = 1'b0;
      chk("t4_next_rdv",   32'(rq_readdatavalid), 32'd2);
      chk("t4_next_rdata", rq_readdata, 32'hCAFEF00D);
      chk("t4_terr_sticky", 32'(timeout_err), 32'd1);

      // ---- 5: reset asserted in WAIT_DATA, late flash response ignored ----
      rq_read = 2'b01;
      rq_addr = {23'h0, 23'h000077};
      tick();
      rq_read = 2'b00;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_busy",  32'(busy), 32'd0);
      chk("t5_read",  32'(fm_read), 32'd0);
      chk("t5_addr",  32'(fm_addr), 32'd0);
      chk("t5_rdata", rq_readdata, 32'd0);
      chk("t5_terr",  32'(timeout_err), 32'd0);
      tick();
      rst_n    = 1'b1;
      fm_rdv   = 1'b1;
      fm_rdata = 32'h77777777;
      tick();
      fm_rdv = 1'b0;
      chk("t5_no_rdv", 32'(rq_readdatavalid), 32'd0);
      chk("t5_idle",   32'(busy), 32'd0);
      chk("t5_rdata_zero", rq_readdata, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
